// File: rtl/cp0_exc_ctrl.sv
// Exception/interrupt sequencer in front of CP0: SYSCALL/ERET/interrupt entry, flush/stall, fetch redirect.
// Optional Count/Compare timer (interrupt source 7) is compiled in when CP0_TIMER_IRQ_EN is defined.
module cp0_exc_ctrl #(
  parameter logic [29:0] EXC_VECTOR  = 30'h0000_1000,
  parameter int          NUM_IRQ     = 6,
  parameter int          SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               id_valid,
  input  logic               id_syscall,
  input  logic               id_eret,
  input  logic [29:0]        id_pc,
  input  logic [NUM_IRQ-1:0] irq,
  input  logic [31:0]        cp0_status,
  input  logic [31:0]        cp0_epc,
  input  logic [2:0]         wr_cp0op,
  input  logic [4:0]         wr_cs,
  input  logic [2:0]         wr_sel,
  input  logic [31:0]        wr_data,
  output logic [2:0]         exc_cp0op,
  output logic [29:0]        exc_pc,
  output logic [4:0]         exc_code,
  output logic               flush,
  output logic               stall,
  output logic               redirect,
  output logic [29:0]        redirect_pc,
  output logic               timer_irq
);

  localparam logic [2:0] OP_NONE  = 3'b000;
  localparam logic [2:0] OP_MTC0  = 3'b010;
  localparam logic [2:0] OP_ENTER = 3'b011;
  localparam logic [2:0] OP_ERET  = 3'b100;
  localparam logic [4:0] CODE_SYS = 5'd8;
  localparam logic [4:0] CODE_INT = 5'd0;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ENTER1 = 3'd1,
    S_ENTER2 = 3'd2,
    S_ERET1  = 3'd3,
    S_ERET2  = 3'd4
  } state_t;

  state_t state_q;

  logic [NUM_IRQ-1:0] sync_q [SYNC_STAGES];
  logic [NUM_IRQ-1:0] prev_q;
  logic [NUM_IRQ-1:0] pend_q;
  logic [NUM_IRQ-1:0] pend_d;
  logic [NUM_IRQ-1:0] rise;
  logic [NUM_IRQ-1:0] clr;
  logic [7:0]         src;
  logic [7:0]         taken;
  logic [2:0]         win_idx;
  logic               timer_q;
  logic               ev_eret;
  logic               ev_sys;
  logic               take_int;

  // Synchroniser chain plus one extra flop so rising edges are seen on the synced line.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
      prev_q <= '0;
      pend_q <= '0;
    end else begin
      sync_q[0] <= irq;
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
      prev_q <= sync_q[SYNC_STAGES-1];
      pend_q <= pend_d;
    end
  end

  assign rise = sync_q[SYNC_STAGES-1] & ~prev_q;

  always_comb begin
    src                = '0;
    src[NUM_IRQ-1:0]   = pend_q;
    src[7]             = timer_q;
    taken              = src & cp0_status[15:8] & {8{cp0_status[0] & ~cp0_status[1]}};
    win_idx            = '0;
    for (int i = 0; i < 8; i++) begin
      if (taken[i]) win_idx = 3'(i);
    end
  end

  assign ev_eret  = id_valid & id_eret;
  assign ev_sys   = id_valid & id_syscall;
  assign take_int = (state_q == S_IDLE) & id_valid & ~id_eret & ~id_syscall & (|taken);

  // Only the winning line is acknowledged; a new edge on the same cycle re-arms it.
  always_comb begin
    clr = '0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      if (take_int && (win_idx == 3'(i))) clr[i] = 1'b1;
    end
    pend_d = (pend_q & ~clr) | rise;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      exc_cp0op   <= OP_NONE;
      exc_pc      <= '0;
      exc_code    <= '0;
      flush       <= 1'b0;
      stall       <= 1'b0;
      redirect    <= 1'b0;
      redirect_pc <= '0;
    end else begin
      exc_cp0op <= OP_NONE;
      flush     <= 1'b0;
      stall     <= 1'b0;
      redirect  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (ev_eret) begin
            state_q   <= S_ERET1;
            exc_cp0op <= OP_ERET;
            flush     <= 1'b1;
            stall     <= 1'b1;
            exc_pc    <= id_pc;
          end else if (ev_sys) begin
            state_q   <= S_ENTER1;
            exc_cp0op <= OP_ENTER;
            flush     <= 1'b1;
            stall     <= 1'b1;
            exc_pc    <= id_pc;
            exc_code  <= CODE_SYS;
          end else if (take_int) begin
            state_q   <= S_ENTER1;
            exc_cp0op <= OP_ENTER;
            flush     <= 1'b1;
            stall     <= 1'b1;
            exc_pc    <= id_pc;
            exc_code  <= CODE_INT;
          end
        end
        S_ENTER1: begin
          state_q     <= S_ENTER2;
          redirect    <= 1'b1;
          redirect_pc <= EXC_VECTOR;
          flush       <= 1'b1;
        end
        S_ERET1: begin
          state_q     <= S_ERET2;
          redirect    <= 1'b1;
          redirect_pc <= cp0_epc[31:2];
          flush       <= 1'b1;
        end
        S_ENTER2, S_ERET2: state_q <= S_IDLE;
        default:           state_q <= S_IDLE;
      endcase
    end
  end

`ifdef CP0_TIMER_IRQ_EN
  logic [31:0] count_q;
  logic [31:0] count_d;
  logic [31:0] compare_q;
  logic        wr_count;
  logic        wr_compare;

  assign wr_count   = (wr_cp0op == OP_MTC0) && (wr_cs == 5'd9)  && (wr_sel == 3'd0);
  assign wr_compare = (wr_cp0op == OP_MTC0) && (wr_cs == 5'd11) && (wr_sel == 3'd0);
  assign count_d    = wr_count ? wr_data : count_q + 32'd1;

  // A Compare write on the matching cycle leaves the interrupt cleared.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q   <= '0;
      compare_q <= '0;
      timer_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      if (wr_compare) begin
        compare_q <= wr_data;
        timer_q   <= 1'b0;
      end else if (count_d == compare_q) begin
        timer_q <= 1'b1;
      end
    end
  end
`else
  logic unused_wr;
  assign timer_q   = 1'b0;
  assign unused_wr = ^{wr_cp0op, wr_cs, wr_sel, wr_data};
`endif

  logic unused_in;
  assign unused_in = ^{cp0_status[31:16], cp0_status[7:2], cp0_epc[1:0]};
  assign timer_irq = timer_q;

endmodule

// File: tb/tb_cp0_exc_ctrl.sv
// Bench for cp0_exc_ctrl: directed scenarios with literal pins, then randomized traffic against a plan-queue model.
module tb_cp0_exc_ctrl;
  localparam int NIRQ = 6;
  localparam int SYNC = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic            id_valid, id_syscall, id_eret;
  logic [29:0]     id_pc;
  logic [NIRQ-1:0] irq;
  logic [31:0]     cp0_status, cp0_epc, wr_data;
  logic [2:0]      wr_cp0op, wr_sel;
  logic [4:0]      wr_cs;
  logic [2:0]      exc_cp0op;
  logic [29:0]     exc_pc, redirect_pc;
  logic [4:0]      exc_code;
  logic            flush, stall, redirect, timer_irq;

  always #5 clk = ~clk;

  cp0_exc_ctrl dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_syscall(id_syscall), .id_eret(id_eret),
    .id_pc(id_pc), .irq(irq), .cp0_status(cp0_status), .cp0_epc(cp0_epc),
    .wr_cp0op(wr_cp0op), .wr_cs(wr_cs), .wr_sel(wr_sel), .wr_data(wr_data),
    .exc_cp0op(exc_cp0op), .exc_pc(exc_pc), .exc_code(exc_code), .flush(flush),
    .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc), .timer_irq(timer_irq)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Expected upcoming output records: {op[36:34], flush, stall, redirect, rpc_from_epc, rpc[29:0]}
  logic [36:0]     exp_q[$];
  logic [2:0]      m_op;
  logic            m_flush, m_stall, m_redir, m_timer;
  logic [29:0]     m_rpc, m_exc_pc;
  logic [4:0]      m_code;
  logic [NIRQ-1:0] m_pend;
  logic [NIRQ-1:0] m_hist [0:SYNC];
  logic [31:0]     m_count, m_compare;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_op = 3'd0; m_flush = 1'b0; m_stall = 1'b0; m_redir = 1'b0; m_timer = 1'b0;
    m_rpc = '0; m_exc_pc = '0; m_code = '0; m_pend = '0;
    for (int k = 0; k <= SYNC; k++) m_hist[k] = '0;
    m_count = '0; m_compare = '0;
  endtask

  // Predicts the DUT outputs after the coming posedge from the inputs currently driven.
  task automatic model_step();
    logic [7:0]      src, tk;
    logic [NIRQ-1:0] rise;
    logic [36:0]     e;
    logic [31:0]     nxt;
    logic            wc, wk;
    int              win;
    if (rst) begin
      model_reset();
      return;
    end
    src = '0;
    src[NIRQ-1:0] = m_pend;
    src[7] = m_timer;
    tk = (cp0_status[0] && !cp0_status[1]) ? (src & cp0_status[15:8]) : 8'h00;
    rise = m_hist[SYNC-1] & ~m_hist[SYNC];
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      m_op = e[36:34]; m_flush = e[33]; m_stall = e[32]; m_redir = e[31];
      if (e[30]) m_rpc = cp0_epc[31:2];
      else if (e[31]) m_rpc = e[29:0];
    end else begin
      m_op = 3'd0; m_flush = 1'b0; m_stall = 1'b0; m_redir = 1'b0;
      if (id_valid && id_eret) begin
        m_op = 3'b100; m_flush = 1'b1; m_stall = 1'b1; m_exc_pc = id_pc;
        exp_q.push_back({3'b000, 1'b1, 1'b0, 1'b1, 1'b1, 30'h0});
        exp_q.push_back(37'h0);
      end else if (id_valid && (id_syscall || tk != 8'h00)) begin
        m_op = 3'b011; m_flush = 1'b1; m_stall = 1'b1; m_exc_pc = id_pc;
        if (id_syscall) m_code = 5'd8;
        else begin
          m_code = 5'd0;
          win = 0;
          for (int i = 7; i >= 0; i--) if (tk[i]) begin win = i; break; end
          if (win < NIRQ) m_pend[win] = 1'b0;
        end
        exp_q.push_back({3'b000, 1'b1, 1'b0, 1'b1, 1'b0, 30'h0000_1000});
        exp_q.push_back(37'h0);
      end
    end
    m_pend = m_pend | rise;
    for (int k = SYNC; k >= 1; k--) m_hist[k] = m_hist[k-1];
    m_hist[0] = irq;
`ifdef CP0_TIMER_IRQ_EN
    wc  = (wr_cp0op == 3'b010) && (wr_cs == 5'd9)  && (wr_sel == 3'd0);
    wk  = (wr_cp0op == 3'b010) && (wr_cs == 5'd11) && (wr_sel == 3'd0);
    nxt = wc ? wr_data : m_count + 32'd1;
    if (wk) m_timer = 1'b0;
    else if (nxt == m_compare) m_timer = 1'b1;
    if (wk) m_compare = wr_data;
    m_count = nxt;
`else
    wc = 1'b0; wk = 1'b0; nxt = '0;
`endif
  endtask

  task automatic compare_all();
    chk("cp0op", 32'(exc_cp0op), 32'(m_op));
    chk("flush", 32'(flush), 32'(m_flush));
    chk("stall", 32'(stall), 32'(m_stall));
    chk("redirect", 32'(redirect), 32'(m_redir));
    chk("timer_irq", 32'(timer_irq), 32'(m_timer));
    if (m_redir) chk("redirect_pc", 32'(redirect_pc), 32'(m_rpc));
    if (m_op != 3'd0) chk("exc_pc", 32'(exc_pc), 32'(m_exc_pc));
    if (m_op == 3'b011) chk("exc_code", 32'(exc_code), 32'(m_code));
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    @(negedge clk);
    compare_all();
  endtask

  logic       st_ie, st_exl;
  logic [7:0] st_im;

  initial begin
    rst = 1'b1; id_valid = 1'b0; id_syscall = 1'b0; id_eret = 1'b0; id_pc = '0;
    irq = '1; cp0_status = '0; cp0_epc = '0; wr_cp0op = '0; wr_cs = '0; wr_sel = '0; wr_data = '0;
    model_reset();

    // Reset with every irq line high
    repeat (3) tick();
    chk("rst_op", 32'(exc_cp0op), 32'd0);
    chk("rst_flush", 32'(flush), 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_redir", 32'(redirect), 32'd0);
    chk("rst_rpc", 32'(redirect_pc), 32'd0);
    chk("rst_excpc", 32'(exc_pc), 32'd0);
    chk("rst_code", 32'(exc_code), 32'd0);
    chk("rst_timer", 32'(timer_irq), 32'd0);
    rst = 1'b0; id_valid = 1'b1;
    repeat (8) begin
      tick();
      chk("ie0_no_redir", 32'(redirect), 32'd0);
    end
    irq = '0; rst = 1'b1; tick(); rst = 1'b0; repeat (4) tick();

    // SYSCALL at 0x40
    id_pc = 30'h40; id_syscall = 1'b1;
    tick();
    chk("sys_op", 32'(exc_cp0op), 32'h3);
    chk("sys_excpc", 32'(exc_pc), 32'h40);
    chk("sys_code", 32'(exc_code), 32'd8);
    chk("sys_redir_early", 32'(redirect), 32'd0);
    id_syscall = 1'b0;
    tick();
    chk("sys_redir", 32'(redirect), 32'd1);
    chk("sys_rpc", 32'(redirect_pc), 32'h1000);
    tick();
    chk("sys_idle", 32'(redirect), 32'd0);

    // ERET with a syscall arriving during ERET1
    cp0_epc = 32'h0000_0104; id_eret = 1'b1;
    tick();
    chk("eret_op", 32'(exc_cp0op), 32'h4);
    id_eret = 1'b0; id_syscall = 1'b1;
    tick();
    chk("eret_redir", 32'(redirect), 32'd1);
    chk("eret_rpc", 32'(redirect_pc), 32'h41);
    id_syscall = 1'b0;
    tick();
    chk("eret_sys_ignored", 32'(exc_cp0op), 32'd0);

    // irq[2] and irq[4] together: 4 first, 2 after EXL clears
    id_valid = 1'b0; cp0_status = 32'h0000_FF01; irq = 6'b010100;
    tick(); irq = '0;
    repeat (4) tick();
    id_valid = 1'b1; id_pc = 30'h200;
    tick();
    chk("irq_a_op", 32'(exc_cp0op), 32'h3);
    chk("irq_a_code", 32'(exc_code), 32'd0);
    cp0_status = 32'h0000_FF03;
    repeat (4) begin
      tick();
      chk("irq_exl_block", 32'(exc_cp0op), 32'd0);
    end
    cp0_status = 32'h0000_FF01;
    tick();
    chk("irq_b_op", 32'(exc_cp0op), 32'h3);
    cp0_status = 32'h0000_FF03;
    repeat (3) tick();

    // Syscall against a pending irq[1]
    id_valid = 1'b0; cp0_status = 32'h0000_FF01; irq = 6'b000010;
    repeat (4) tick();
    id_valid = 1'b1; id_syscall = 1'b1;
    tick();
    chk("mix_code_sys", 32'(exc_code), 32'd8);
    id_syscall = 1'b0; cp0_status = 32'h0000_FF03;
    repeat (4) begin
      tick();
      chk("mix_blocked", 32'(exc_cp0op), 32'd0);
    end
    cp0_status = 32'h0000_FF01;
    tick();
    chk("mix_irq_op", 32'(exc_cp0op), 32'h3);
    chk("mix_irq_code", 32'(exc_code), 32'd0);
    cp0_status = 32'h0000_FF03; irq = '0;
    repeat (3) tick();

`ifdef CP0_TIMER_IRQ_EN
    // Compare=10 then Count=0: timer fires 10 clocks after the Count write
    id_valid = 1'b0; cp0_status = 32'h0000_8001;
    wr_cp0op = 3'b010; wr_cs = 5'd11; wr_sel = 3'd0; wr_data = 32'd10;
    tick();
    wr_cs = 5'd9; wr_data = 32'd0;
    tick();
    wr_cp0op = 3'b000;
    repeat (9) begin
      tick();
      chk("tmr_early", 32'(timer_irq), 32'd0);
    end
    tick();
    chk("tmr_set", 32'(timer_irq), 32'd1);
    id_valid = 1'b1;
    tick();
    chk("tmr_entry_op", 32'(exc_cp0op), 32'h3);
    chk("tmr_entry_code", 32'(exc_code), 32'd0);
    cp0_status = 32'h0000_8003;
    repeat (2) tick();
    wr_cp0op = 3'b010; wr_cs = 5'd11; wr_data = 32'hFFFF_FFF0;
    tick();
    chk("tmr_clear", 32'(timer_irq), 32'd0);
    wr_cp0op = 3'b000;
    tick();
`endif

    // Randomized traffic
    st_ie = 1'b1; st_exl = 1'b0; st_im = 8'hFF;
    for (int n = 0; n < 3000; n++) begin
      rst        = ($urandom_range(0, 499) == 0);
      id_valid   = ($urandom_range(0, 3) != 0);
      id_syscall = ($urandom_range(0, 9) == 0);
      id_eret    = ($urandom_range(0, 15) == 0);
      id_pc      = 30'($urandom);
      cp0_epc    = $urandom;
      if ($urandom_range(0, 7) == 0) irq = NIRQ'($urandom);
      if (m_op == 3'b011) st_exl = 1'b1;
      else if ($urandom_range(0, 5) == 0) st_exl = 1'b0;
      if ($urandom_range(0, 40) == 0) st_ie = ~st_ie;
      if ($urandom_range(0, 60) == 0) st_im = 8'($urandom);
      cp0_status = {16'($urandom), st_im, 6'($urandom), st_exl, st_ie};
      wr_cp0op = ($urandom_range(0, 15) == 0) ? 3'b010 : 3'($urandom_range(0, 1));
      case ($urandom_range(0, 2))
        0: begin wr_cs = 5'd9;  wr_data = 32'($urandom_range(0, 40)); end
        1: begin wr_cs = 5'd11; wr_data = 32'($urandom_range(0, 60)); end
        default: begin wr_cs = 5'd12; wr_data = $urandom; end
      endcase
      wr_sel = ($urandom_range(0, 7) == 0) ? 3'd1 : 3'd0;
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
